// File: rtl/config_loader_pkg.sv
// Shared types and defaults for the configuration scan-chain loader.
package config_loader_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// One-word buffer that turns accepted stream words into a bit stream, LSB first.
// An empty buffer passes bit 0 of the incoming word straight through so intake costs no bubble.
module cfg_word_serializer
  import config_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_active,
  input  logic              i_last,
  input  logic              i_take_bit,
  input  logic [WORD_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic              o_bit_valid,
  output logic              o_bit
);

  localparam int IDX_W = idx_width(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic              r_full;
  logic              w_at_end;
  logic              w_accept;

  // Refuse a new word while the final chain bit is leaving, so no word is over-consumed.
  assign w_at_end    = r_full && (r_idx == LAST_IDX);
  assign o_s_ready   = i_active && (!r_full || (w_at_end && !i_last));
  assign w_accept    = o_s_ready && i_s_valid;
  assign o_bit_valid = r_full || w_accept;
  assign o_bit       = r_full ? r_word[r_idx] : i_s_data[0];

  // Buffer and bit-index update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_flush) begin
      r_word <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_take_bit) begin
      if (r_full && !w_at_end) begin
        r_idx <= r_idx + IDX_W'(1);
      end else if (w_accept && r_full) begin
        r_word <= i_s_data;
        r_idx  <= '0;
        r_full <= 1'b1;
      end else if (w_accept) begin
        r_word <= i_s_data;
        r_idx  <= (WORD_W > 1) ? IDX_W'(1) : '0;
        r_full <= (WORD_W > 1);
      end else begin
        r_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// Sequencer that clears a daisy-chained config scan chain, shifts in chain_len bits
// from a word stream, and flags any tail activity seen while the cleared chain fills.
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RST_CYCLES = 2
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  chain_len,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              chain_in,
  output logic              chain_en,
  output logic              chain_rst,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int RC_W = idx_width(RST_CYCLES + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [RC_W-1:0]  r_rst_cnt;
  logic             r_chain_rst;
  logic             r_chain_en;
  logic             r_chain_in;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic             w_bit_valid;
  logic             w_bit;

  cfg_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk         (config_clk),
    .rst_n       (config_reset),
    .i_flush     (r_state == ST_CLEAR),
    .i_active    (r_state == ST_LOAD),
    .i_last      (r_remaining == CNT_W'(1)),
    .i_take_bit  ((r_state == ST_LOAD) && w_bit_valid),
    .i_s_data    (s_data),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .o_bit_valid (w_bit_valid),
    .o_bit       (w_bit)
  );

  // Load sequencer with registered chain controls and status.
  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_rst_cnt   <= '0;
      r_chain_rst <= 1'b0;
      r_chain_en  <= 1'b0;
      r_chain_in  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // A cleared chain must present 0 at its tail while it fills.
      if (r_chain_en && chain_tail) begin
        r_error <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_done     <= 1'b0;
          r_chain_en <= 1'b0;
          r_chain_in <= 1'b0;
          if (start) begin
            r_remaining <= chain_len;
            r_error     <= 1'b0;
            r_rst_cnt   <= RC_W'(RST_CYCLES - 1);
            r_chain_rst <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_CLEAR;
          end else begin
            r_chain_rst <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_rst_cnt == '0) begin
            r_chain_rst <= 1'b0;
            if (r_remaining == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_LOAD;
            end
          end else begin
            r_rst_cnt <= r_rst_cnt - RC_W'(1);
          end
        end
        ST_LOAD: begin
          r_chain_en <= w_bit_valid;
          r_chain_in <= w_bit_valid & w_bit;
          if (w_bit_valid) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done     <= 1'b0;
          r_chain_en <= 1'b0;
          r_chain_in <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_chain_rst <= 1'b0;
          r_chain_en  <= 1'b0;
          r_chain_in  <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign chain_in  = r_chain_in;
  assign chain_en  = r_chain_en;
  assign chain_rst = r_chain_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: a physical chain model, a word feeder and
// per-cycle checks of outputs against timing derived from start, RST_CYCLES and chain_len.
module tb_config_chain_loader;

  localparam int WORD_W     = 32;
  localparam int CNT_W      = 16;
  localparam int RST_CYCLES = 2;

  logic              config_clk = 1'b0;
  logic              config_reset;
  logic              start;
  logic [CNT_W-1:0]  chain_len;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              chain_in;
  logic              chain_en;
  logic              chain_rst;
  logic              chain_tail;
  logic              busy;
  logic              done;
  logic              error;

  config_chain_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)) dut (
    .config_clk   (config_clk),
    .config_reset (config_reset),
    .start        (start),
    .chain_len    (chain_len),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .chain_in     (chain_in),
    .chain_en     (chain_en),
    .chain_rst    (chain_rst),
    .chain_tail   (chain_tail),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 config_clk = ~config_clk;

  int          checks = 0;
  int          failures = 0;
  bit          chain_m [0:127];
  int          clen_m;
  logic [31:0] word_arr [0:3];
  int          gap_arr [0:3];
  int          nwords;
  int          next_word, gap_cnt;
  logic        err_exp;
  int          cyc, exp_done, hs_cnt, en_cnt, rst_cnt, done_cnt, done_cyc;
  int          stall_cnt, zero_run, stuck_shift;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the chain model.
  task automatic step(input logic st, input logic [CNT_W-1:0] len);
    logic hs, tail, busy_exp;
    @(negedge config_clk);
    busy_exp = (cyc >= 1) && (cyc <= exp_done);
    check("error", 64'(error), 64'(err_exp));
    check("busy", 64'(busy), 64'(busy_exp));
    check("done", 64'(done), 64'(cyc == exp_done));
    check("chain_rst", 64'(chain_rst), 64'((cyc >= 1) && (cyc <= RST_CYCLES)));
    if (!busy || chain_rst) check("s_ready_not_loading", 64'(s_ready), 64'd0);
    if (chain_rst) check("chain_en_in_clear", 64'(chain_en), 64'd0);
    if (!chain_en) check("chain_in_idle", 64'(chain_in), 64'd0);
    start = st;
    chain_len = len;
    if (next_word < nwords) begin
      if (gap_cnt > 0) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        if (s_ready) gap_cnt--;
      end else begin
        s_valid = 1'b1;
        s_data  = word_arr[next_word];
      end
    end else begin
      s_valid = 1'b0;
      s_data  = $urandom;
    end
    hs = s_valid && s_ready;
    if (hs) begin
      hs_cnt++;
      next_word++;
      gap_cnt = (next_word < nwords) ? gap_arr[next_word] : 0;
    end
    tail = chain_m[clen_m-1];
    if (chain_en && (en_cnt + 1 == stuck_shift)) tail = 1'b1;
    chain_tail = tail;
    if (st && !busy_exp) err_exp = 1'b0;
    else if (chain_en && tail) err_exp = 1'b1;
    if (chain_rst) begin
      for (int i = 0; i < 128; i++) chain_m[i] = 1'b0;
    end else if (chain_en) begin
      for (int i = 127; i > 0; i--) chain_m[i] = chain_m[i-1];
      chain_m[0] = chain_in;
    end
    if (chain_en) begin
      en_cnt++;
      stall_cnt += zero_run;
      zero_run = 0;
    end else if (en_cnt > 0) begin
      zero_run++;
    end
    if (chain_rst) rst_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic run_load(input int len, input int exp_d, input int exp_hs, input int exp_stall,
                          input int stuck, input int restart_cyc, input int abort_at);
    int bad;
    clen_m = (len > 0) ? len : 1;
    cyc = 0; exp_done = exp_d;
    hs_cnt = 0; en_cnt = 0; rst_cnt = 0; done_cnt = 0; done_cyc = -1;
    stall_cnt = 0; zero_run = 0; stuck_shift = stuck;
    next_word = 0;
    gap_cnt = (nwords > 0) ? gap_arr[0] : 0;
    step(1'b1, CNT_W'(len));
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      step(cyc == restart_cyc, (cyc == restart_cyc) ? CNT_W'(5) : CNT_W'(len));
      if (abort_at > 0 && en_cnt == abort_at) begin
        #2 config_reset = 1'b0;
        #1 check("reset_midload_outputs",
                 64'({s_ready, chain_in, chain_en, chain_rst, busy, done, error}), 64'd0);
        err_exp = 1'b0;
        next_word = nwords;
        @(posedge config_clk);
        @(negedge config_clk);
        start = 1'b0; s_valid = 1'b0; chain_tail = 1'b0;
        config_reset = 1'b1;
        return;
      end
    end
    step(1'b0, CNT_W'(len));
    step(1'b0, CNT_W'(len));
    check("done_count", 64'(done_cnt), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(exp_d));
    check("handshakes", 64'(hs_cnt), 64'(exp_hs));
    check("shift_count", 64'(en_cnt), 64'(len));
    check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    check("clear_cycles", 64'(rst_cnt), 64'(RST_CYCLES));
    bad = 0;
    for (int k = 0; k < len; k++) begin
      if (chain_m[len-1-k] !== word_arr[k/32][k%32]) bad++;
    end
    check("chain_contents", 64'(bad), 64'd0);
  endtask

  initial begin
    int ones;
    config_reset = 1'b1; start = 1'b0; chain_len = '0; s_valid = 1'b0; s_data = '0;
    chain_tail = 1'b0; cyc = 0; exp_done = 0; err_exp = 1'b0; nwords = 0;
    for (int i = 0; i < 128; i++) chain_m[i] = 1'b0;
    #2 config_reset = 1'b0;
    #5 check("reset_outputs", 64'({s_ready, chain_in, chain_en, chain_rst, busy, done, error}), 64'd0);
    repeat (2) @(negedge config_clk);
    config_reset = 1'b1;

    // Single word: bits 0 then 1, done at cycle 5.
    nwords = 1; word_arr[0] = 32'h2; gap_arr[0] = 0;
    run_load(2, 5, 1, 0, 0, -1, 0);
    check("t1_chain_literal", 64'({chain_m[0], chain_m[1]}), 64'h2);

    // Streaming three words over 70 bits; the third word's upper bits are dropped.
    nwords = 3; word_arr[0] = 32'hFFFF_FFFF; word_arr[1] = 32'h0; word_arr[2] = 32'h3F;
    gap_arr[0] = 0; gap_arr[1] = 0; gap_arr[2] = 0;
    run_load(70, 73, 3, 0, 0, -1, 0);
    ones = 0;
    for (int k = 0; k < 70; k++) ones += int'(chain_m[k]);
    check("t2_ones_literal", 64'(ones), 64'd38);

    // Underrun: second word withheld, five stalled cycles.
    nwords = 2; word_arr[0] = 32'hA5A5_A5A5; word_arr[1] = 32'h0000_00C3;
    gap_arr[0] = 0; gap_arr[1] = 6;
    run_load(40, 48, 2, 5, 0, -1, 0);

    // Stuck tail on the third shift: sticky error.
    nwords = 1; word_arr[0] = 32'h5A; gap_arr[0] = 0;
    run_load(8, 11, 1, 0, 3, -1, 0);
    check("t4_error_sticky", 64'(error), 64'd1);

    // Zero-length chain with a word offered: no shift, no handshake, error cleared.
    nwords = 1; word_arr[0] = 32'hDEAD_BEEF; gap_arr[0] = 0;
    run_load(0, 3, 0, 0, 0, -1, 0);
    check("t5_error_cleared", 64'(error), 64'd0);

    // Start pulsed mid-load is ignored.
    nwords = 1; word_arr[0] = 32'h1234; gap_arr[0] = 0;
    run_load(16, 19, 1, 0, 0, 6, 0);

    // Reset at bit 10 of 64, then a full reload.
    nwords = 2; word_arr[0] = 32'hDEAD_BEEF; word_arr[1] = 32'hCAFE_F00D;
    gap_arr[0] = 0; gap_arr[1] = 0;
    run_load(64, 67, 2, 0, 0, -1, 10);
    nwords = 2; word_arr[0] = 32'h1357_9BDF; word_arr[1] = 32'h2468_ACE0;
    run_load(64, 67, 2, 0, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Sequencer that programs one daisy-chained configuration scan chain, such as the chain of single-bit config cells inside switch cells like the 1-to-2 fully connected crossbar. It accepts configuration words from the host/DMA side over a valid/ready stream. It clears the chain, then serializes exactly `chain_len` bits into the chain head with a shift-enable for the chain's clock gate. It checks the chain tail for stuck/broken links and reports completion.

## Interface
Parameters:
- `WORD_W`, 32, width of incoming configuration words.
- `CNT_W`, 16, width of the bit counter; maximum chain length is 2^CNT_W−1.
- `RST_CYCLES`, 2, number of cycles `chain_rst` is held in CLEAR (≥1).

Ports:
- `config_clk`, in, 1, the single clock. All logic is on its rising edge.
- `config_reset`, in, 1, asynchronous, active-low reset.
- `start`, in, 1, begin a load. Sampled only in IDLE.
- `chain_len`, in, CNT_W, number of config bits in the chain. Latched on accepted `start`.
- `s_data`, in, WORD_W, configuration word, LSB shifted first.
- `s_valid`, in, 1, `s_data` is valid.
- `s_ready`, out, 1, loader accepts a word this cycle.
- `chain_in`, out, 1, drives the chain head `config_in`.
- `chain_en`, out, 1, shift enable for the chain's clock gate. The chain shifts one position on each cycle it is high.
- `chain_rst`, out, 1, active-high reset to the chain cells' `config_reset`.
- `chain_tail`, in, 1, from the chain's last `config_out`.
- `busy`, out, 1, high in any state other than IDLE.
- `done`, out, 1, one-cycle pulse on completion.
- `error`, out, 1, sticky tail-check failure. Cleared on the next accepted `start`.

## Operation
- The state machine has four states: IDLE, CLEAR, LOAD, DONE.
- **IDLE**
  - When `start`=1: latch `chain_len`, clear `error`, go to CLEAR.
- **CLEAR**
  - `chain_rst`=1 for RST_CYCLES cycles.
  - `chain_en`=0.
  - The word buffer is flushed.
  - Next state is LOAD, or DONE directly if latched `chain_len`=0.
- **LOAD**
  - The word buffer holds one word plus a bit index (0..WORD_W−1).
  - `s_ready`=1 when the buffer is empty, or when its last bit (index WORD_W−1) shifts this cycle. A new word can therefore be accepted with no bubble.
  - On a cycle where the buffer holds a bit:
    - `chain_en`=1 and `chain_in`=current bit.
    - The bit index increments and the remaining count decrements.
  - With the buffer empty: `chain_en`=0 and `chain_in`=0. This is an underrun: the chain stalls with no data corruption.
  - Tail check: on every cycle with `chain_en`=1, `chain_tail` must be 0, since the chain was cleared. If it is 1, set `error`. The load continues regardless.
  - When the remaining count reaches 0 after a shift, go to DONE.
  - Unused high bits of the final word are discarded.
  - `s_ready` falls in the cycle the last bit shifts. No extra word is consumed.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- Bit order: bit 0 of the first word is shifted first and ends at the chain's far (tail) cell.
- `start` while `busy` is ignored.
- `s_valid` outside LOAD is ignored and `s_ready`=0.

## Timing
- Reset values (async, while `config_reset`=0):
  - State is IDLE.
  - `s_ready`, `chain_in`, `chain_en`, `chain_rst`, `busy`, `done`, `error` are all 0.
  - Counters and buffer are cleared.
- Reset mid-load aborts immediately. Partial chain contents are left in place, and the next load re-clears them.
- Cycle counts:
  - `start` accepted in cycle 0: `chain_rst` is high in cycles 1..RST_CYCLES.
  - LOAD is entered at cycle RST_CYCLES+1.
  - With no underrun, the last shift occurs at cycle RST_CYCLES+chain_len, and `done` is high the following cycle.
- All outputs are registered, except `s_ready`, which is combinational from state and buffer status only (no path from `s_valid`).
- Throughput is one chain bit per cycle when `s_valid` is held high.

## Structure
- Package `config_loader_pkg`:
  - state enum (IDLE/CLEAR/LOAD/DONE)
  - default WORD_W and CNT_W
- Sub-module `cfg_word_serializer`:
  - one-word buffer, bit index, valid/ready intake, bit output
  - `take_bit` input, `bit_valid` output
  - The top FSM owns the remaining count, the tail check and the chain reset.

## Test plan
- **Single word:** WORD_W=32, chain_len=2, word 0x2. Expected: `chain_rst` high 2 cycles. `chain_in` shifts 0 then 1 on consecutive `chain_en` cycles. `done` pulses at cycle 5. One `s_ready`&`s_valid` handshake. `error`=0.
- **Multi-word streaming:** chain_len=70, three words 0xFFFFFFFF, 0x0, 0x3F, `s_valid` held. Expected: 70 contiguous `chain_en` cycles. The third word's bits 6..31 are never shifted. Exactly 3 handshakes.
- **Underrun:** chain_len=40, second word delayed 5 cycles. Expected: `chain_en`=0 for those 5 cycles. The chain model's final contents equal the expected 40-bit pattern. `done` arrives 5 cycles later.
- **Stuck tail:** force `chain_tail`=1 on the 3rd shift. Expected: `error` rises the next cycle and remains set through `done`. A new `start` clears it.
- **chain_len=0, busy start:** chain_len=0 gives CLEAR then `done` with no `chain_en` and no handshakes. `start` pulsed during LOAD is ignored.
- **Reset mid-load:** assert `config_reset`=0 at bit 10 of 64. Expected: all outputs 0 immediately. A subsequent full load completes with correct chain contents.
